vga_sprite_renderer: RTL and testbench

- Parametrised successor to the grid-based VGA display block.
- Generates 640x480@60 timing (defaults) from a single pixel clock and overlays one frog cell and NUM_OBJ variable-length horizontal objects on an externally supplied background.
- New capabilities:
  - per-object length with enable;
  - horizontal wrap-around;
  - frame-boundary latching of positions (tear-free);
  - hard blanking outside the active area;
  - per-frame frog/object collision report.
- Sits between the game logic (positions) and the VGA pins.

---
 rtl/vga_sprite_renderer.sv | 195 +++++++++++++++++++
 tb/tb_vga_sprite_renderer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_renderer.sv
// VGA timing generator with a frog cell and NUM_OBJ wrapping horizontal objects
// drawn over an external background. Positions are latched once per frame, and
// each frame reports whether the frog overlapped any object.
module vga_sprite_renderer #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned CELL_LOG2 = 5,
  parameter int unsigned GRID_COLS = 20,
  parameter int unsigned GRID_ROWS = 15,
  parameter int unsigned COL_W     = 5,
  parameter int unsigned ROW_W     = 4,
  parameter int unsigned NUM_OBJ   = 11,
  parameter int unsigned LEN_W     = 3,
  parameter logic [8:0]  FROG_RGB  = 9'h1FF,
  parameter logic [8:0]  OBJ_RGB   = 9'h1C0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [COL_W-1:0]           frog_col,
  input  logic [ROW_W-1:0]           frog_row,
  input  logic [NUM_OBJ*COL_W-1:0]   obj_x,
  input  logic [NUM_OBJ*ROW_W-1:0]   obj_y,
  input  logic [NUM_OBJ*LEN_W-1:0]   obj_len,
  output logic [9:0]                 pix_x,
  output logic [9:0]                 pix_y,
  input  logic [8:0]                 bg_rgb,
  output logic [2:0]                 vga_r,
  output logic [2:0]                 vga_g,
  output logic [2:0]                 vga_b,
  output logic                       vga_hs,
  output logic                       vga_vs,
  output logic                       frame_tick,
  output logic                       collision
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] GC      = 10'(GRID_COLS);
  localparam logic [9:0] GR      = 10'(GRID_ROWS);

  logic [9:0] h, v;

  // shadow copies of the game-logic positions, valid once the first frame latch happened
  logic [COL_W-1:0]         sh_frog_col;
  logic [ROW_W-1:0]         sh_frog_row;
  logic [NUM_OBJ*COL_W-1:0] sh_obj_x;
  logic [NUM_OBJ*ROW_W-1:0] sh_obj_y;
  logic [NUM_OBJ*LEN_W-1:0] sh_obj_len;
  logic                     sh_vld;

  logic [9:0] col_c, row_c, ox, oy, ol, od;
  logic       active_c, hs_c, vs_c, first_c, last_c;
  logic       frog_hit_c, obj_hit_c, hit_c;

  logic       act1, hs1, vs1, first1, frog1, obj1, acc, coll_snap;
  logic [8:0] bg1, rgb_c;

  assign pix_x = h;
  assign pix_y = v;

  assign col_c    = h >> CELL_LOG2;
  assign row_c    = v >> CELL_LOG2;
  assign active_c = (h < H_ACT) && (v < V_ACT);
  assign hs_c     = !((h >= HS_BEG) && (h < HS_END));
  assign vs_c     = !((v >= VS_BEG) && (v < VS_END));
  assign first_c  = (h == 10'd0) && (v == 10'd0);
  assign last_c   = (h == H_LAST) && (v == V_LAST);
  assign hit_c    = active_c && frog_hit_c && obj_hit_c;

  // raster counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h <= 10'd0;
      v <= 10'd0;
    end else if (h == H_LAST) begin
      h <= 10'd0;
      v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // latch positions on the last counter cycle of the frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_frog_col <= '0;
      sh_frog_row <= '0;
      sh_obj_x    <= '0;
      sh_obj_y    <= '0;
      sh_obj_len  <= '0;
      sh_vld      <= 1'b0;
    end else if (last_c) begin
      sh_frog_col <= frog_col;
      sh_frog_row <= frog_row;
      sh_obj_x    <= obj_x;
      sh_obj_y    <= obj_y;
      sh_obj_len  <= obj_len;
      sh_vld      <= 1'b1;
    end
  end

  // frog and object hit test for the current counter cell
  always_comb begin
    ox        = '0;
    oy        = '0;
    ol        = '0;
    od        = '0;
    obj_hit_c = 1'b0;
    frog_hit_c = sh_vld && (10'(sh_frog_col) < GC) && (10'(sh_frog_row) < GR) &&
                 (col_c == 10'(sh_frog_col)) && (row_c == 10'(sh_frog_row));
    for (int unsigned i = 0; i < NUM_OBJ; i++) begin
      ox = 10'(sh_obj_x[i*COL_W +: COL_W]);
      oy = 10'(sh_obj_y[i*ROW_W +: ROW_W]);
      ol = 10'(sh_obj_len[i*LEN_W +: LEN_W]);
      if (ol > GC) ol = GC;
      // distance from the object start, wrapping at the right screen edge
      od = (col_c >= ox) ? (col_c - ox) : (col_c + GC - ox);
      if (sh_vld && (ol != 10'd0) && (ox < GC) && (row_c == oy) && (od < ol))
        obj_hit_c = 1'b1;
    end
  end

  // stage 1: register pixel attributes and accumulate per-frame collision
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act1      <= 1'b0;
      hs1       <= 1'b1;
      vs1       <= 1'b1;
      first1    <= 1'b0;
      frog1     <= 1'b0;
      obj1      <= 1'b0;
      bg1       <= '0;
      acc       <= 1'b0;
      coll_snap <= 1'b0;
    end else begin
      act1   <= active_c;
      hs1    <= hs_c;
      vs1    <= vs_c;
      first1 <= first_c;
      frog1  <= frog_hit_c;
      obj1   <= obj_hit_c;
      bg1    <= bg_rgb;
      if (first_c) begin
        coll_snap <= acc;
        acc       <= hit_c;
      end else if (hit_c) begin
        acc <= 1'b1;
      end
    end
  end

  // colour priority: blanking, frog, object, background
  always_comb begin
    rgb_c = 9'd0;
    if (act1) begin
      if (frog1)     rgb_c = FROG_RGB;
      else if (obj1) rgb_c = OBJ_RGB;
      else           rgb_c = bg1;
    end
  end

  // stage 2: registered VGA outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_r      <= 3'd0;
      vga_g      <= 3'd0;
      vga_b      <= 3'd0;
      vga_hs     <= 1'b1;
      vga_vs     <= 1'b1;
      frame_tick <= 1'b0;
      collision  <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= rgb_c;
      vga_hs     <= hs1;
      vga_vs     <= vs1;
      frame_tick <= first1;
      if (first1) collision <= coll_snap;
    end
  end

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Bench for vga_sprite_renderer on a reduced raster (48x28 total, 4-pixel cells):
// a per-cycle scoreboard plus table-driven probe/collision vectors and timing sequences.
module tb_vga_sprite_renderer;

  localparam int HA = 40, HFP = 2, HSY = 4, HBP = 2;
  localparam int VA = 24, VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int CL = 2, GCOLS = 10, GROWS = 6;
  localparam int CW = 5, RW = 4, NO = 3, LW = 4;
  localparam logic [8:0] FROG = 9'h1FF;
  localparam logic [8:0] OBJ  = 9'h1C0;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CW-1:0]    frog_col = '0;
  logic [RW-1:0]    frog_row = '0;
  logic [NO*CW-1:0] obj_x = '0;
  logic [NO*RW-1:0] obj_y = '0;
  logic [NO*LW-1:0] obj_len = '0;
  logic [9:0]       pix_x, pix_y;
  logic [8:0]       bg_rgb;
  logic [2:0]       vga_r, vga_g, vga_b;
  logic             vga_hs, vga_vs, frame_tick, collision;

  function automatic logic [8:0] bg_fn(input logic [9:0] x, input logic [9:0] y);
    return {x[4:2], y[4:2], 3'b010};
  endfunction

  assign bg_rgb = bg_fn(pix_x, pix_y);

  vga_sprite_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .CELL_LOG2(CL), .GRID_COLS(GCOLS), .GRID_ROWS(GROWS),
    .COL_W(CW), .ROW_W(RW), .NUM_OBJ(NO), .LEN_W(LW),
    .FROG_RGB(FROG), .OBJ_RGB(OBJ)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frog_col(frog_col), .frog_row(frog_row),
    .obj_x(obj_x), .obj_y(obj_y), .obj_len(obj_len),
    .pix_x(pix_x), .pix_y(pix_y), .bg_rgb(bg_rgb),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_tick(frame_tick), .collision(collision)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // ---------------- scoreboard model ----------------
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [8:0] rgb;
    logic       hs;
    logic       vs;
    logic       tick;
    logic       coll;
  } sb_t;

  localparam sb_t RST_E = '{x: 10'h3FF, y: 10'h3FF, rgb: 9'd0, hs: 1'b1, vs: 1'b1,
                            tick: 1'b0, coll: 1'b0};

  sb_t  sbq[$];
  sb_t  e, cur;
  int   mh, mv, mfc, mfr;
  int   mox[NO], moy[NO], mol[NO];
  logic mvld, macc, mcoll, m_act, m_fh, m_oh;

  int         probe_x, probe_y;
  logic       probe_arm = 1'b0;
  logic       probe_got = 1'b0;
  logic [8:0] probe_val;

  // object coverage by enumerating the cells each object spans
  function automatic logic m_obj_cover(input int c, input int r);
    for (int i = 0; i < NO; i++) begin
      int len;
      len = (mol[i] > GCOLS) ? GCOLS : mol[i];
      if (mox[i] < GCOLS && moy[i] == r)
        for (int k = 0; k < len; k++)
          if ((mox[i] + k) % GCOLS == c) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mh = 0; mv = 0; mvld = 1'b0; macc = 1'b0; mcoll = 1'b0;
      mfc = 0; mfr = 0;
      for (int i = 0; i < NO; i++) begin mox[i] = 0; moy[i] = 0; mol[i] = 0; end
      sbq.delete();
      sbq.push_back(RST_E);
      sbq.push_back(RST_E);
    end else begin
      m_act = (mh < HA) && (mv < VA);
      m_fh  = m_act && mvld && ((mh >> CL) == mfc) && ((mv >> CL) == mfr);
      m_oh  = m_act && mvld && m_obj_cover(mh >> CL, mv >> CL);
      if (mh == 0 && mv == 0) begin
        mcoll = macc;
        macc  = m_fh && m_oh;
      end else if (m_fh && m_oh) begin
        macc = 1'b1;
      end
      e.x    = 10'(mh);
      e.y    = 10'(mv);
      e.rgb  = !m_act ? 9'd0 : m_fh ? FROG : m_oh ? OBJ : bg_fn(10'(mh), 10'(mv));
      e.hs   = !(mh >= HA + HFP && mh < HA + HFP + HSY);
      e.vs   = !(mv >= VA + VFP && mv < VA + VFP + VSY);
      e.tick = (mh == 0 && mv == 0);
      e.coll = mcoll;
      sbq.push_back(e);
      if (mh == HT - 1 && mv == VT - 1) begin
        mvld = 1'b1;
        mfc  = int'(frog_col);
        mfr  = int'(frog_row);
        for (int i = 0; i < NO; i++) begin
          mox[i] = int'(obj_x[i*CW +: CW]);
          moy[i] = int'(obj_y[i*RW +: RW]);
          mol[i] = int'(obj_len[i*LW +: LW]);
        end
      end
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    cur = sbq.pop_front();
    #1;
    n_cmp++;
    if ({vga_r, vga_g, vga_b} !== cur.rgb || vga_hs !== cur.hs || vga_vs !== cur.vs ||
        frame_tick !== cur.tick || collision !== cur.coll ||
        pix_x !== 10'(mh) || pix_y !== 10'(mv)) begin
      n_bad++;
      $display("FAIL pixel(%0d,%0d): got rgb=%h hs=%b vs=%b tick=%b coll=%b pix=(%0d,%0d) expected rgb=%h hs=%b vs=%b tick=%b coll=%b pix=(%0d,%0d)",
               cur.x, cur.y, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, frame_tick, collision,
               pix_x, pix_y, cur.rgb, cur.hs, cur.vs, cur.tick, cur.coll, mh, mv);
    end
    if (probe_arm && !probe_got && cur.x == 10'(probe_x) && cur.y == 10'(probe_y)) begin
      probe_val = {vga_r, vga_g, vga_b};
      probe_got = 1'b1;
    end
  end

  // ---------------- directed tests ----------------
  typedef struct {
    int fc, fr;
    int ox0, oy0, ol0;
    int ox1, oy1, ol1;
    int px, py;
    logic [8:0] exp_rgb;
    logic exp_coll;
  } vec_t;

  function automatic vec_t mk(input int fc, input int fr, input int ox0, input int oy0,
                              input int ol0, input int ox1, input int oy1, input int ol1,
                              input int px, input int py, input logic [8:0] rgb,
                              input logic coll);
    vec_t t;
    t.fc = fc; t.fr = fr; t.ox0 = ox0; t.oy0 = oy0; t.ol0 = ol0;
    t.ox1 = ox1; t.oy1 = oy1; t.ol1 = ol1; t.px = px; t.py = py;
    t.exp_rgb = rgb; t.exp_coll = coll;
    return t;
  endfunction

  task automatic apply(input vec_t t);
    frog_col = CW'(t.fc);
    frog_row = RW'(t.fr);
    obj_x    = {CW'(0), CW'(t.ox1), CW'(t.ox0)};
    obj_y    = {RW'(0), RW'(t.oy1), RW'(t.oy0)};
    obj_len  = {LW'(0), LW'(t.ol1), LW'(t.ol0)};
  endtask

  task automatic wait_tick(input string nm, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (frame_tick !== 1'b1 && cyc < 2 * FRAME);
    if (frame_tick !== 1'b1) chk({nm, "_tick_timeout"}, cyc, -1);
  endtask

  task automatic arm(input int x, input int y);
    probe_x = x; probe_y = y; probe_got = 1'b0; probe_arm = 1'b1;
  endtask

  vec_t tv[13];
  int   c, hs_cnt, vs_cnt, first_hs, first_vs;

  initial begin
    tv[0]  = mk(3, 2, 0, 0, 0, 0, 0, 0, 13,  9, FROG, 1'b0);
    tv[1]  = mk(3, 2, 0, 0, 0, 0, 0, 0, 16,  9, bg_fn(10'd16, 10'd9), 1'b0);
    tv[2]  = mk(3, 2, 0, 0, 0, 0, 0, 0, 42,  5, 9'd0, 1'b0);
    tv[3]  = mk(3, 2, 8, 5, 4, 0, 0, 0, 36, 21, OBJ, 1'b0);
    tv[4]  = mk(3, 2, 8, 5, 4, 0, 0, 0,  4, 20, OBJ, 1'b0);
    tv[5]  = mk(3, 2, 8, 5, 4, 0, 0, 0,  8, 20, bg_fn(10'd8, 10'd20), 1'b0);
    tv[6]  = mk(1, 5, 8, 5, 4, 0, 0, 0,  5, 21, FROG, 1'b1);
    tv[7]  = mk(1, 4, 8, 5, 4, 0, 0, 0,  5, 21, OBJ, 1'b0);
    tv[8]  = mk(5, 5, 25, 5, 4, 0, 0, 0, 0, 21, bg_fn(10'd0, 10'd21), 1'b0);
    tv[9]  = mk(0, 6, 2, 0, 15, 0, 0, 0, 39,  2, OBJ, 1'b0);
    tv[10] = mk(7, 0, 2, 0, 15, 0, 0, 0, 29,  1, FROG, 1'b1);
    tv[11] = mk(5, 1, 0, 0, 0, 9, 3, 2,  1, 13, OBJ, 1'b0);
    tv[12] = mk(3, 2, 3, 2, 0, 0, 0, 0, 13,  9, FROG, 1'b0);

    apply(mk(0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 9'd0, 1'b0));
    repeat (3) @(negedge clk);
    chk("reset_rgb", int'({vga_r, vga_g, vga_b}), 0);
    chk("reset_syncs", int'({vga_hs, vga_vs}), 3);
    chk("reset_tick_coll", int'({frame_tick, collision}), 0);
    rst_n = 1'b1;
    wait_tick("first", c);
    chk("first_tick_latency", c, 2);
    chk("first_pixel_bg", int'({vga_r, vga_g, vga_b}), int'(bg_fn(10'd0, 10'd0)));
    wait_tick("period", c);
    chk("frame_period", c, FRAME);

    // sync placement over one frame, indexed from the tick cycle
    hs_cnt = 0; vs_cnt = 0; first_hs = -1; first_vs = -1;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      if (!vga_hs) begin
        if (k < HT) hs_cnt++;
        if (first_hs < 0) first_hs = k;
      end
      if (!vga_vs) begin
        vs_cnt++;
        if (first_vs < 0) first_vs = k;
      end
    end
    chk("hs_width", hs_cnt, HSY);
    chk("hs_start", first_hs, HA + HFP);
    chk("vs_width", vs_cnt, VSY * HT);
    chk("vs_start", first_vs, (VA + VFP) * HT);
    wait_tick("align", c);

    // table: inputs take effect one frame later, probe and collision read the frame after
    for (int i = 0; i < 13; i++) begin
      apply(tv[i]);
      wait_tick("vec_a", c);
      arm(tv[i].px, tv[i].py);
      wait_tick("vec_b", c);
      probe_arm = 1'b0;
      chk($sformatf("vec%0d_probe_seen", i), int'(probe_got), 1);
      chk($sformatf("vec%0d_rgb", i), int'(probe_val), int'(tv[i].exp_rgb));
      chk($sformatf("vec%0d_collision", i), int'(collision), int'(tv[i].exp_coll));
    end

    // mid-frame position change must not show until the next frame
    apply(mk(0, 6, 8, 5, 4, 0, 0, 0, 0, 0, 9'd0, 1'b0));
    wait_tick("mid_a", c);
    wait_tick("mid_b", c);
    repeat (10 * HT) @(negedge clk);
    obj_x = {CW'(0), CW'(0), CW'(0)};
    arm(36, 21);
    wait_tick("mid_c", c);
    chk("midframe_same_frame", int'(probe_val), int'(OBJ));
    arm(36, 21);
    wait_tick("mid_d", c);
    chk("midframe_next_frame", int'(probe_val), int'(bg_fn(10'd36, 10'd21)));
    arm(12, 21);
    wait_tick("mid_e", c);
    probe_arm = 1'b0;
    chk("midframe_new_pos", int'(probe_val), int'(OBJ));

    // reset pulse mid-frame while a collision is being reported
    apply(mk(1, 5, 8, 5, 4, 0, 0, 0, 0, 0, 9'd0, 1'b0));
    wait_tick("rst_a", c);
    wait_tick("rst_b", c);
    chk("pre_reset_collision", int'(collision), 1);
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_collision", int'(collision), 0);
    chk("midreset_syncs", int'({vga_hs, vga_vs}), 3);
    wait_tick("rst_first", c);
    chk("midreset_tick_latency", c, 2);
    wait_tick("rst_t1", c);
    chk("post_reset_frame1_coll", int'(collision), 0);
    wait_tick("rst_t2", c);
    chk("post_reset_frame2_coll", int'(collision), 1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
